instr_encode_queue: RTL and testbench

//  Inverse of the core's instruction decode: turns (op_t, register/immediate fields) requests into 32-bit MIPS32 words.

---
 rtl/instr_encode_queue_pkg.sv | 174 +++++++++++++++++
 rtl/instr_encode_queue_if.sv | 32 +++
 rtl/instr_encode_queue_fifo.sv | 58 +++++
 rtl/instr_encode_queue.sv | 86 ++++++++
 tb/tb_instr_encode_queue.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encode_queue_pkg.sv
// rtl/instr_encode_queue_pkg.sv - MIPS32 op list, field constants, request struct and encode/decode helpers
// INSTR_ENC_SELFCHECK_EN adds decode_word() used by the optional re-decode checker.
package instr_encode_queue_pkg;

    typedef enum logic [5:0] {
        OP_NOP, OP_SLL, OP_SRL, OP_SRA,
        OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_JR, OP_SYSCALL, OP_BREAK, OP_BLTZ, OP_BGEZ, OP_J, OP_JAL,
        OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI,
        OP_LB, OP_LW, OP_SB, OP_SW, OP_MFC0, OP_MTC0, OP_ERET,
        OP_MUL, OP_MADD, OP_DECODE_ERROR
    } op_t;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_REGIMM   = 6'h01;
    localparam logic [5:0] OPC_J        = 6'h02;
    localparam logic [5:0] OPC_JAL      = 6'h03;
    localparam logic [5:0] OPC_BEQ      = 6'h04;
    localparam logic [5:0] OPC_BNE      = 6'h05;
    localparam logic [5:0] OPC_ADDIU    = 6'h09;
    localparam logic [5:0] OPC_SLTI     = 6'h0A;
    localparam logic [5:0] OPC_ANDI     = 6'h0C;
    localparam logic [5:0] OPC_ORI      = 6'h0D;
    localparam logic [5:0] OPC_LUI      = 6'h0F;
    localparam logic [5:0] OPC_COP0     = 6'h10;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OPC_LB       = 6'h20;
    localparam logic [5:0] OPC_LW       = 6'h23;
    localparam logic [5:0] OPC_SB       = 6'h28;
    localparam logic [5:0] OPC_SW       = 6'h2B;

    localparam logic [5:0] FUNCT_SLL     = 6'h00;
    localparam logic [5:0] FUNCT_SRL     = 6'h02;
    localparam logic [5:0] FUNCT_SRA     = 6'h03;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0] FUNCT_BREAK   = 6'h0D;
    localparam logic [5:0] FUNCT_ADDU    = 6'h21;
    localparam logic [5:0] FUNCT_SUBU    = 6'h23;
    localparam logic [5:0] FUNCT_AND     = 6'h24;
    localparam logic [5:0] FUNCT_OR      = 6'h25;
    localparam logic [5:0] FUNCT_XOR     = 6'h26;
    localparam logic [5:0] FUNCT_NOR     = 6'h27;
    localparam logic [5:0] FUNCT_SLT     = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU    = 6'h2B;

    localparam logic [4:0] RI_BLTZ = 5'h00;
    localparam logic [4:0] RI_BGEZ = 5'h01;
    localparam logic [4:0] CP0_MF  = 5'h00;
    localparam logic [4:0] CP0_MT  = 5'h04;
    localparam logic [5:0] SP2_MADD = 6'h00;
    localparam logic [5:0] SP2_MUL  = 6'h02;

    localparam logic [31:0] ERET_WORD = 32'h42000018;

    typedef struct packed {
        op_t         op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } enc_req_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] f);
        return {OPC_SPECIAL, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // Returns {legal, word}; fields an op does not use are passed as zero.
    function automatic logic [32:0] encode_req(input enc_req_t r);
        logic [31:0] w;
        logic        ok;
        w  = '0;
        ok = 1'b1;
        case (r.op)
            OP_NOP:     w = '0;
            OP_SLL:     w = r_word(5'd0, r.rt, r.rd, r.shamt, FUNCT_SLL);
            OP_SRL:     w = r_word(5'd0, r.rt, r.rd, r.shamt, FUNCT_SRL);
            OP_SRA:     w = r_word(5'd0, r.rt, r.rd, r.shamt, FUNCT_SRA);
            OP_ADDU:    w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_ADDU);
            OP_SUBU:    w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_SUBU);
            OP_AND:     w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_AND);
            OP_OR:      w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_OR);
            OP_XOR:     w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_XOR);
            OP_NOR:     w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_NOR);
            OP_SLT:     w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_SLT);
            OP_SLTU:    w = r_word(r.rs, r.rt, r.rd, 5'd0, FUNCT_SLTU);
            OP_JR:      w = r_word(r.rs, 5'd0, 5'd0, 5'd0, FUNCT_JR);
            OP_SYSCALL: w = {OPC_SPECIAL, r.target[19:0], FUNCT_SYSCALL};
            OP_BREAK:   w = {OPC_SPECIAL, r.target[19:0], FUNCT_BREAK};
            OP_BLTZ:    w = {OPC_REGIMM, r.rs, RI_BLTZ, r.imm};
            OP_BGEZ:    w = {OPC_REGIMM, r.rs, RI_BGEZ, r.imm};
            OP_J:       w = {OPC_J, r.target};
            OP_JAL:     w = {OPC_JAL, r.target};
            OP_BEQ:     w = i_word(OPC_BEQ, r.rs, r.rt, r.imm);
            OP_BNE:     w = i_word(OPC_BNE, r.rs, r.rt, r.imm);
            OP_ADDIU:   w = i_word(OPC_ADDIU, r.rs, r.rt, r.imm);
            OP_SLTI:    w = i_word(OPC_SLTI, r.rs, r.rt, r.imm);
            OP_ANDI:    w = i_word(OPC_ANDI, r.rs, r.rt, r.imm);
            OP_ORI:     w = i_word(OPC_ORI, r.rs, r.rt, r.imm);
            OP_LUI:     w = i_word(OPC_LUI, 5'd0, r.rt, r.imm);
            OP_LB:      w = i_word(OPC_LB, r.rs, r.rt, r.imm);
            OP_LW:      w = i_word(OPC_LW, r.rs, r.rt, r.imm);
            OP_SB:      w = i_word(OPC_SB, r.rs, r.rt, r.imm);
            OP_SW:      w = i_word(OPC_SW, r.rs, r.rt, r.imm);
            OP_MFC0:    w = {OPC_COP0, CP0_MF, r.rt, r.rd, 11'd0};
            OP_MTC0:    w = {OPC_COP0, CP0_MT, r.rt, r.rd, 11'd0};
            OP_ERET:    w = ERET_WORD;
            OP_MUL:     w = {OPC_SPECIAL2, r.rs, r.rt, r.rd, 5'd0, SP2_MUL};
            OP_MADD:    w = {OPC_SPECIAL2, r.rs, r.rt, 5'd0, 5'd0, SP2_MADD};
            default:    ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

`ifdef INSTR_ENC_SELFCHECK_EN
    function automatic op_t decode_word(input logic [31:0] w);
        op_t op;
        op = OP_DECODE_ERROR;
        case (w[31:26])
            OPC_SPECIAL: begin
                case (w[5:0])
                    FUNCT_SLL:     op = (w == 32'h0) ? OP_NOP : OP_SLL;
                    FUNCT_SRL:     op = OP_SRL;
                    FUNCT_SRA:     op = OP_SRA;
                    FUNCT_JR:      op = OP_JR;
                    FUNCT_SYSCALL: op = OP_SYSCALL;
                    FUNCT_BREAK:   op = OP_BREAK;
                    FUNCT_ADDU:    op = OP_ADDU;
                    FUNCT_SUBU:    op = OP_SUBU;
                    FUNCT_AND:     op = OP_AND;
                    FUNCT_OR:      op = OP_OR;
                    FUNCT_XOR:     op = OP_XOR;
                    FUNCT_NOR:     op = OP_NOR;
                    FUNCT_SLT:     op = OP_SLT;
                    FUNCT_SLTU:    op = OP_SLTU;
                    default:       op = OP_DECODE_ERROR;
                endcase
            end
            OPC_REGIMM:   op = (w[20:16] == RI_BLTZ) ? OP_BLTZ :
                               (w[20:16] == RI_BGEZ) ? OP_BGEZ : OP_DECODE_ERROR;
            OPC_J:        op = OP_J;
            OPC_JAL:      op = OP_JAL;
            OPC_BEQ:      op = OP_BEQ;
            OPC_BNE:      op = OP_BNE;
            OPC_ADDIU:    op = OP_ADDIU;
            OPC_SLTI:     op = OP_SLTI;
            OPC_ANDI:     op = OP_ANDI;
            OPC_ORI:      op = OP_ORI;
            OPC_LUI:      op = OP_LUI;
            OPC_LB:       op = OP_LB;
            OPC_LW:       op = OP_LW;
            OPC_SB:       op = OP_SB;
            OPC_SW:       op = OP_SW;
            OPC_COP0:     op = (w == ERET_WORD)        ? OP_ERET :
                               (w[25:21] == CP0_MT)    ? OP_MTC0 :
                               (w[25:21] == CP0_MF)    ? OP_MFC0 : OP_DECODE_ERROR;
            OPC_SPECIAL2: op = (w[5:0] == SP2_MUL)  ? OP_MUL :
                               (w[5:0] == SP2_MADD) ? OP_MADD : OP_DECODE_ERROR;
            default:      op = OP_DECODE_ERROR;
        endcase
        return op;
    endfunction
`endif

endpackage

// File: rtl/instr_encode_queue_if.sv
// rtl/instr_encode_queue_if.sv - request/response/status bundle between requester and encode queue
interface instr_encode_queue_if #(parameter int CNT_W = 16);
    import instr_encode_queue_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_t              in_op;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [4:0]       in_rd;
    logic [4:0]       in_shamt;
    logic [15:0]      in_imm;
    logic [25:0]      in_target;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             err_pulse;
    logic             err_sticky;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] ill_cnt;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, flush, out_ready,
        input  in_ready, out_valid, out_instr, err_pulse, err_sticky, enc_cnt, ill_cnt
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, flush, out_ready,
        output in_ready, out_valid, out_instr, err_pulse, err_sticky, enc_cnt, ill_cnt
    );
endinterface

// File: rtl/instr_encode_queue_fifo.sv
// rtl/instr_encode_queue_fifo.sv - instr_encode_fifo: DEPTH-entry valid/ready FIFO with synchronous flush
module instr_encode_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Readiness depends only on stored state, so a pop never opens a slot in the same cycle.
    assign in_ready  = (count < DEPTH_C) && !flush;
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign do_push   = in_valid && in_ready;
    assign do_pop    = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_encode_queue.sv
// rtl/instr_encode_queue.sv - encodes op/field requests into MIPS32 words and queues them for fetch injection
// INSTR_ENC_SELFCHECK_EN: re-decode every pushed word and flag mismatches on err_sticky.
module instr_encode_queue
    import instr_encode_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    instr_encode_queue_if.slave bus
);
    enc_req_t         req;
    logic [32:0]      enc;
    logic             fifo_in_ready;
    logic             accept;
    logic             push;
    logic             ill_acc;
    logic             err_set;
    logic             err_pulse_q;
    logic             err_sticky_q;
    logic [CNT_W-1:0] enc_cnt_q;
    logic [CNT_W-1:0] ill_cnt_q;

    assign req = '{op: bus.in_op, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                   shamt: bus.in_shamt, imm: bus.in_imm, target: bus.in_target};
    assign enc = encode_req(req);

    // Illegal requests are consumed like legal ones but never reach the FIFO.
    assign accept  = bus.in_valid && fifo_in_ready;
    assign push    = accept && enc[32];
    assign ill_acc = accept && !enc[32];

    assign bus.in_ready = fifo_in_ready;

    instr_encode_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (push),
        .in_ready  (fifo_in_ready),
        .in_data   (enc[31:0]),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_instr)
    );

`ifdef INSTR_ENC_SELFCHECK_EN
    logic chk_bad;
    // An all-zero word decodes as NOP, which is also a legitimate SLL $0,$0,0.
    assign chk_bad = push && (decode_word(enc[31:0]) != bus.in_op) && (enc[31:0] != 32'h0);
    assign err_set = ill_acc || chk_bad;

    always_ff @(posedge clk) begin
        if (chk_bad) begin
            $error("instr_encode_queue: re-decode of %h does not match requested op %0d",
                   enc[31:0], bus.in_op);
        end
    end
`else
    assign err_set = ill_acc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            enc_cnt_q    <= '0;
            ill_cnt_q    <= '0;
        end else begin
            err_pulse_q <= ill_acc;
            if (bus.flush) begin
                err_sticky_q <= 1'b0;
            end else if (err_set) begin
                err_sticky_q <= 1'b1;
            end
            if (push && (enc_cnt_q != '1)) enc_cnt_q <= enc_cnt_q + 1'b1;
            if (ill_acc && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + 1'b1;
        end
    end

    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.enc_cnt    = enc_cnt_q;
    assign bus.ill_cnt    = ill_cnt_q;
endmodule

// File: tb/tb_instr_encode_queue.sv
// tb/tb_instr_encode_queue.sv - directed and randomized bench for instr_encode_queue against a word-level model
module tb_instr_encode_queue;
    import instr_encode_queue_pkg::*;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    instr_encode_queue_if #(.CNT_W(CNT_W)) bus ();

    instr_encode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] mq[$];
    int          m_enc;
    int          m_ill;
    logic        m_pulse;
    logic        m_sticky;
    logic        acc_last;

    op_t         r_op;
    logic [4:0]  r_rs, r_rt, r_rd, r_sh;
    logic [15:0] r_imm;
    logic [25:0] r_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference encoder built directly from the MIPS32 field layout using numeric opcodes.
    function automatic logic [32:0] ref_encode(input op_t op, input int unsigned rs, input int unsigned rt,
                                               input int unsigned rd, input int unsigned sh,
                                               input int unsigned imm, input int unsigned tgt);
        int unsigned w;
        logic        ok;
        int unsigned rrr;
        int unsigned ri;
        ok  = 1'b1;
        rrr = (rs << 21) | (rt << 16) | (rd << 11);
        ri  = (rs << 21) | (rt << 16) | imm;
        case (op)
            OP_NOP:     w = 0;
            OP_SLL:     w = (rt << 16) | (rd << 11) | (sh << 6) | 0;
            OP_SRL:     w = (rt << 16) | (rd << 11) | (sh << 6) | 2;
            OP_SRA:     w = (rt << 16) | (rd << 11) | (sh << 6) | 3;
            OP_ADDU:    w = rrr | 33;
            OP_SUBU:    w = rrr | 35;
            OP_AND:     w = rrr | 36;
            OP_OR:      w = rrr | 37;
            OP_XOR:     w = rrr | 38;
            OP_NOR:     w = rrr | 39;
            OP_SLT:     w = rrr | 42;
            OP_SLTU:    w = rrr | 43;
            OP_JR:      w = (rs << 21) | 8;
            OP_SYSCALL: w = ((tgt % (1 << 20)) << 6) | 12;
            OP_BREAK:   w = ((tgt % (1 << 20)) << 6) | 13;
            OP_BLTZ:    w = (1 << 26) | (rs << 21) | (0 << 16) | imm;
            OP_BGEZ:    w = (1 << 26) | (rs << 21) | (1 << 16) | imm;
            OP_J:       w = (2 << 26) | tgt;
            OP_JAL:     w = (3 << 26) | tgt;
            OP_BEQ:     w = (4 << 26) | ri;
            OP_BNE:     w = (5 << 26) | ri;
            OP_ADDIU:   w = (9 << 26) | ri;
            OP_SLTI:    w = (10 << 26) | ri;
            OP_ANDI:    w = (12 << 26) | ri;
            OP_ORI:     w = (13 << 26) | ri;
            OP_LUI:     w = (15 << 26) | (rt << 16) | imm;
            OP_LB:      w = (32 << 26) | ri;
            OP_LW:      w = (35 << 26) | ri;
            OP_SB:      w = (40 << 26) | ri;
            OP_SW:      w = (43 << 26) | ri;
            OP_MFC0:    w = (16 << 26) | (0 << 21) | (rt << 16) | (rd << 11);
            OP_MTC0:    w = (16 << 26) | (4 << 21) | (rt << 16) | (rd << 11);
            OP_ERET:    w = 32'h42000018;
            OP_MUL:     w = (28 << 26) | rrr | 2;
            OP_MADD:    w = (28 << 26) | (rs << 21) | (rt << 16);
            default: begin
                w  = 0;
                ok = 1'b0;
            end
        endcase
        return {ok, w};
    endfunction

    task automatic set_req(input op_t op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
        r_op = op; r_rs = rs; r_rt = rt; r_rd = rd; r_sh = sh; r_imm = imm; r_tgt = tgt;
    endtask

    task automatic check_outputs();
        chk("out_valid",  {31'd0, bus.out_valid},  {31'd0, mq.size() > 0});
        chk("out_instr",  bus.out_instr,           (mq.size() > 0) ? mq[0] : 32'h0);
        chk("err_pulse",  {31'd0, bus.err_pulse},  {31'd0, m_pulse});
        chk("err_sticky", {31'd0, bus.err_sticky}, {31'd0, m_sticky});
        chk("enc_cnt",    32'(bus.enc_cnt),        32'(m_enc));
        chk("ill_cnt",    32'(bus.ill_cnt),        32'(m_ill));
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs at negedge.
    task automatic step(input logic v, input logic rdy, input logic fl);
        logic [32:0] e;
        logic        fits;
        bus.in_valid  = v;
        bus.in_op     = r_op;
        bus.in_rs     = r_rs;
        bus.in_rt     = r_rt;
        bus.in_rd     = r_rd;
        bus.in_shamt  = r_sh;
        bus.in_imm    = r_imm;
        bus.in_target = r_tgt;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
        fits = (mq.size() < DEPTH) && !fl;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, fits});
        acc_last = v && fits;
        e = ref_encode(r_op, r_rs, r_rt, r_rd, r_sh, r_imm, r_tgt);
        @(posedge clk);
        m_pulse = 1'b0;
        if (fl) begin
            mq.delete();
            m_sticky = 1'b0;
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (acc_last && e[32]) begin
                mq.push_back(e[31:0]);
                if (m_enc < CNT_MAX) m_enc++;
            end else if (acc_last) begin
                m_pulse  = 1'b1;
                m_sticky = 1'b1;
                if (m_ill < CNT_MAX) m_ill++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic rdy);
        acc_last = 1'b0;
        for (int k = 0; k < 10 && !acc_last; k++) step(1'b1, rdy, 1'b0);
        chk("accept_within_bound", {31'd0, acc_last}, 32'd1);
    endtask

    task automatic model_reset();
        mq.delete();
        m_enc = 0; m_ill = 0; m_pulse = 1'b0; m_sticky = 1'b0;
    endtask

    initial begin
        logic [5:0] opn;
        rst = 1'b1;
        set_req(OP_NOP, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0; bus.in_op = OP_NOP; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        set_req(OP_ADDIU, 29, 29, 0, 0, 16'hFFF8, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("addiu_word", bus.out_instr, 32'h27BDFFF8);
        chk("addiu_enc_cnt", 32'(bus.enc_cnt), 32'd1);
        step(1'b0, 1'b1, 1'b0);

        set_req(OP_JAL, 0, 0, 0, 0, 0, 26'h0100000);
        step(1'b1, 1'b1, 1'b0);
        chk("jal_word", bus.out_instr, 32'h0C100000);
        set_req(OP_SLL, 0, 3, 2, 4, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("sll_word", bus.out_instr, 32'h00031100);
        set_req(OP_NOP, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("nop_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("nop_word", bus.out_instr, 32'h00000000);

        set_req(OP_MTC0, 0, 8, 12, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("mtc0_word", bus.out_instr, 32'h40886000);
        set_req(OP_ERET, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("eret_word", bus.out_instr, 32'h42000018);
        step(1'b0, 1'b1, 1'b0);

        set_req(OP_ADDU, 1, 2, 3, 0, 0, 0);  step(1'b1, 1'b0, 1'b0);
        set_req(OP_ORI, 4, 5, 0, 0, 16'h1234, 0); step(1'b1, 1'b0, 1'b0);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        set_req(OP_LW, 6, 7, 0, 0, 16'h0040, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("full_hold_word", bus.out_instr, 32'h00221821);
        send(1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        set_req(OP_DECODE_ERROR, 1, 1, 1, 1, 1, 1);
        step(1'b1, 1'b1, 1'b0);
        chk("illegal_pulse", {31'd0, bus.err_pulse}, 32'd1);
        chk("illegal_sticky", {31'd0, bus.err_sticky}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("flush_sticky", {31'd0, bus.err_sticky}, 32'd0);
        opn = 6'd60;
        set_req(op_t'(opn), 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        set_req(OP_SW, 9, 10, 0, 0, 16'h0008, 0); step(1'b1, 1'b0, 1'b0);
        set_req(OP_BEQ, 11, 12, 0, 0, 16'hFFFF, 0); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        set_req(OP_BNE, 1, 2, 0, 0, 16'h0010, 0); step(1'b1, 1'b0, 1'b0);
        set_req(OP_SRA, 0, 4, 5, 31, 0, 0); step(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_enc", 32'(bus.enc_cnt), 32'd0);
        chk("async_rst_ill", 32'(bus.ill_cnt), 32'd0);
        chk("async_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_req(OP_ADDIU, 29, 29, 0, 0, 16'hFFF8, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_word", bus.out_instr, 32'h27BDFFF8);

        for (int i = 0; i < 600; i++) begin
            opn = ($urandom_range(0, 99) < 85) ? 6'($urandom_range(0, 34)) : 6'($urandom_range(35, 63));
            set_req(op_t'(opn), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    16'($urandom), 26'($urandom));
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
